// File: rtl/keccak_absorb_ctrl.sv
// Keccak sponge absorb sequencer: byte-swaps message words into lanes, pads, and
// hands rate blocks to an external permutation. Optional: KECCAK_ABSORB_BLKCNT_EN.

module load64 #(
  parameter int BW_DATA = 64
) (
  input  logic [BW_DATA-1:0] i_word,
  output logic [BW_DATA-1:0] o_lane
);
  // Stream byte 0 sits in the word MSBs but belongs in the lane LSBs.
  always_comb begin
    for (int b = 0; b < BW_DATA/8; b++) begin
      o_lane[8*b +: 8] = i_word[BW_DATA-8-8*b +: 8];
    end
  end
endmodule

module keccak_absorb_ctrl #(
  parameter int          BW_DATA    = 64,
  parameter int          BW_STATE   = 1600,
  parameter int          RATE_LANES = 21,
  parameter logic [7:0]  DS         = 8'h1F
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_start,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [BW_DATA-1:0]  i_data,
  input  logic                i_last,
  input  logic [3:0]          i_bytes,
  output logic                o_perm_start,
  input  logic                i_perm_done,
  input  logic [BW_STATE-1:0] i_perm_state,
  output logic [BW_STATE-1:0] o_state,
`ifdef KECCAK_ABSORB_BLKCNT_EN
  output logic [15:0]         o_blk_cnt,
`endif
  output logic                o_done
);

  localparam int             NLANES   = BW_STATE / BW_DATA;
  localparam int             IW       = 5;
  localparam logic [IW-1:0]  LAST_IDX = IW'(RATE_LANES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ABSORB, S_PERM, S_PAD, S_DONE} fsm_e;

  fsm_e                st_q, st_d;
  logic [BW_STATE-1:0] state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW-1:0]       pad_lane_q, pad_lane_d;
  logic [2:0]          pad_byte_q, pad_byte_d;
  logic                final_q, final_d;
  logic                pend_pad_q, pend_pad_d;
  logic                busy_q, busy_d;

  logic [3:0]          bytes_eff;
  logic [BW_DATA-1:0]  word_m;
  logic [BW_DATA-1:0]  lane_in;
  logic [BW_DATA-1:0]  ds_lane;
  logic                start_ok;

  always_comb begin
    word_m    = '0;
    bytes_eff = 4'd8;
    if (i_last && i_bytes < 4'd8) bytes_eff = i_bytes;
    for (int b = 0; b < BW_DATA/8; b++) begin
      if (4'(b) < bytes_eff) word_m[BW_DATA-8-8*b +: 8] = i_data[BW_DATA-8-8*b +: 8];
    end
  end

  load64 #(.BW_DATA(BW_DATA)) u_load64 (
    .i_word (word_m),
    .o_lane (lane_in)
  );

  assign ds_lane  = BW_DATA'(DS) << {pad_byte_q, 3'b000};
  assign start_ok = (st_q == S_IDLE || st_q == S_DONE) && i_start;

  always_comb begin
    // NOTE: every combinational output gets a default up front so no path leaves it
    // unassigned, which would otherwise infer a latch.
    st_d         = st_q;
    state_d      = state_q;
    idx_d        = idx_q;
    pad_lane_d   = pad_lane_q;
    pad_byte_d   = pad_byte_q;
    final_d      = final_q;
    pend_pad_d   = pend_pad_q;
    busy_d       = busy_q;
    o_ready      = 1'b0;
    o_perm_start = 1'b0;
    o_done       = 1'b0;

    unique case (st_q)
      S_IDLE, S_DONE: begin
        o_done = (st_q == S_DONE);
        if (start_ok) begin
          state_d    = '0;
          idx_d      = '0;
          final_d    = 1'b0;
          pend_pad_d = 1'b0;
          st_d       = S_ABSORB;
        end
      end

      S_ABSORB: begin
        o_ready = 1'b1;
        if (i_valid) begin
          for (int k = 0; k < NLANES; k++) begin
            if (IW'(k) == idx_q) state_d[BW_DATA*k +: BW_DATA] = state_q[BW_DATA*k +: BW_DATA] ^ lane_in;
          end
          if (!i_last) begin
            if (idx_q == LAST_IDX) begin
              final_d    = 1'b0;
              pend_pad_d = 1'b0;
              st_d       = S_PERM;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else if (bytes_eff < 4'd8) begin
            pad_lane_d = idx_q;
            pad_byte_d = bytes_eff[2:0];
            st_d       = S_PAD;
          end else if (idx_q < LAST_IDX) begin
            pad_lane_d = idx_q + 1'b1;
            pad_byte_d = 3'd0;
            st_d       = S_PAD;
          end else begin
            // Full last word closes the block: pad lands in the next block.
            pad_lane_d = '0;
            pad_byte_d = 3'd0;
            final_d    = 1'b0;
            pend_pad_d = 1'b1;
            st_d       = S_PERM;
          end
        end
      end

      S_PAD: begin
        for (int k = 0; k < NLANES; k++) begin
          if (IW'(k) == pad_lane_q) state_d[BW_DATA*k +: BW_DATA] = state_d[BW_DATA*k +: BW_DATA] ^ ds_lane;
          if (IW'(k) == LAST_IDX)
            state_d[BW_DATA*k +: BW_DATA] = state_d[BW_DATA*k +: BW_DATA] ^ {8'h80, {(BW_DATA-8){1'b0}}};
        end
        final_d = 1'b1;
        st_d    = S_PERM;
      end

      S_PERM: begin
        o_perm_start = !busy_q;
        busy_d       = 1'b1;
        if (busy_q && i_perm_done) begin
          state_d = i_perm_state;
          idx_d   = '0;
          busy_d  = 1'b0;
          if (final_q) begin
            st_d = S_DONE;
          end else if (pend_pad_q) begin
            pend_pad_d = 1'b0;
            st_d       = S_PAD;
          end else begin
            st_d = S_ABSORB;
          end
        end
      end

      default: st_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      st_q       <= S_IDLE;
      state_q    <= '0;
      idx_q      <= '0;
      pad_lane_q <= '0;
      pad_byte_q <= '0;
      final_q    <= 1'b0;
      pend_pad_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      pad_lane_q <= pad_lane_d;
      pad_byte_q <= pad_byte_d;
      final_q    <= final_d;
      pend_pad_q <= pend_pad_d;
      busy_q     <= busy_d;
    end
  end

  assign o_state = state_q;

`ifdef KECCAK_ABSORB_BLKCNT_EN
  logic [15:0] blk_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      blk_cnt_q <= '0;
    end else if (start_ok) begin
      blk_cnt_q <= '0;
    end else if (o_perm_start && blk_cnt_q != 16'hFFFF) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  assign o_blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// Directed bench for keccak_absorb_ctrl: single-word vector table plus block-boundary,
// shared-pad, reset-abort and protocol sequences.

module tb_keccak_absorb_ctrl;

  logic          i_clk = 1'b0;
  logic          i_rstn, i_start, i_valid, i_last, i_perm_done;
  logic [63:0]   i_data;
  logic [3:0]    i_bytes;
  logic [1599:0] i_perm_state;
  logic          o_ready, o_perm_start, o_done;
  logic [1599:0] o_state;
  logic          o_ready1, o_perm_start1, o_done1;
  logic [1599:0] o_state1;

  always #5 i_clk = ~i_clk;

  keccak_absorb_ctrl #(.RATE_LANES(21), .DS(8'h1F)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_valid(i_valid),
    .o_ready(o_ready), .i_data(i_data), .i_last(i_last), .i_bytes(i_bytes),
    .o_perm_start(o_perm_start), .i_perm_done(i_perm_done),
    .i_perm_state(i_perm_state), .o_state(o_state), .o_done(o_done)
  );

  keccak_absorb_ctrl #(.RATE_LANES(1), .DS(8'h1F)) dut1 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_valid(i_valid),
    .o_ready(o_ready1), .i_data(i_data), .i_last(i_last), .i_bytes(i_bytes),
    .o_perm_start(o_perm_start1), .i_perm_done(i_perm_done),
    .i_perm_state(i_perm_state), .o_state(o_state1), .o_done(o_done1)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  nbytes;
    logic [63:0] lane0;
    logic [63:0] lane1;
  } vec_t;

  vec_t vecs [5];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   pcnt   = 0;

  always @(negedge i_clk) if (o_perm_start) pcnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] lane(input logic [1599:0] s, input int k);
    return s[64*k +: 64];
  endfunction

  function automatic logic [1599:0] pat(input int seed);
    logic [1599:0] s;
    for (int k = 0; k < 25; k++) s[64*k +: 64] = 64'hA5A5_0000_0000_0000 ^ (64'(seed) << 32) ^ 64'(k);
    return s;
  endfunction

  task automatic do_reset;
    i_rstn = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_bytes = '0;
    i_data = '0; i_perm_done = 1'b0; i_perm_state = '0;
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic do_start;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic last, input logic [3:0] nb);
    int n = 0;
    while (!o_ready && n < 50) begin @(negedge i_clk); n++; end
    check("ready_wait", {63'b0, o_ready}, 64'd1);
    i_valid = 1'b1; i_data = d; i_last = last; i_bytes = nb;
    @(negedge i_clk);
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic wait_pstart(input bit which, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 60) begin
      if (which ? o_perm_start1 : o_perm_start) begin ok = 1'b1; break; end
      @(negedge i_clk);
      n++;
    end
    check(which ? "pstart1_seen" : "pstart_seen", {63'b0, ok}, 64'd1);
  endtask

  task automatic finish_perm(input logic [1599:0] ps);
    @(negedge i_clk);
    check("pstart_one_cycle", {63'b0, o_perm_start}, 64'd0);
    i_perm_done = 1'b1; i_perm_state = ps;
    @(negedge i_clk);
    i_perm_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            ok;
    logic [1599:0] r;
    logic [1599:0] p1, p2;
    logic [63:0]   held;

    vecs[0] = '{64'hDEADBEEF_CAFEF00D, 4'd0, 64'h0000_0000_0000_001F, 64'h0};
    vecs[1] = '{64'hAABBCCDD_EEFF0011, 4'd3, 64'h0000_0000_1FCC_BBAA, 64'h0};
    vecs[2] = '{64'h01020304_05060708, 4'd8, 64'h0807_0605_0403_0201, 64'h1F};
    vecs[3] = '{64'h11223344_55667788, 4'd1, 64'h0000_0000_0000_1F11, 64'h0};
    vecs[4] = '{64'h01020304_05060708, 4'd7, 64'h1F07_0605_0403_0201, 64'h0};

    // Reset state
    do_reset;
    check("rst_ready", {63'b0, o_ready}, 64'd0);
    check("rst_pstart", {63'b0, o_perm_start}, 64'd0);
    check("rst_done", {63'b0, o_done}, 64'd0);
    check("rst_state", {63'b0, |o_state}, 64'd0);

    // Single-word messages, each padded and permuted once
    for (int i = 0; i < 5; i++) begin
      do_reset;
      do_start;
      send(vecs[i].data, 1'b1, vecs[i].nbytes);
      wait_pstart(1'b0, ok);
      check($sformatf("v%0d_lane0", i), lane(o_state, 0), vecs[i].lane0);
      check($sformatf("v%0d_lane1", i), lane(o_state, 1), vecs[i].lane1);
      check($sformatf("v%0d_lane20", i), lane(o_state, 20), 64'h8000_0000_0000_0000);
      r = o_state; r[0 +: 64] = '0; r[64 +: 64] = '0; r[1280 +: 64] = '0;
      check($sformatf("v%0d_rest", i), {63'b0, |r}, 64'd0);
      check($sformatf("v%0d_noready", i), {63'b0, o_ready}, 64'd0);
      p1 = pat(i + 10);
      finish_perm(p1);
      check($sformatf("v%0d_done", i), {63'b0, o_done}, 64'd1);
      check($sformatf("v%0d_final", i), lane(o_state, 4), lane(p1, 4));
    end

    // Byte order, ignored i_start and i_perm_done in ABSORB
    do_reset;
    do_start;
    send(64'h01020304_05060708, 1'b0, 4'd0);
    check("bo_lane0", lane(o_state, 0), 64'h0807_0605_0403_0201);
    do_start;
    i_perm_done = 1'b1; i_perm_state = pat(7);
    @(negedge i_clk);
    i_perm_done = 1'b0;
    check("bo_lane0_held", lane(o_state, 0), 64'h0807_0605_0403_0201);
    check("bo_lane5_held", lane(o_state, 5), 64'h0);
    check("bo_ready", {63'b0, o_ready}, 64'd1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
    wait_pstart(1'b0, ok);
    check("bo_lane0", lane(o_state, 0), 64'h0807_0605_0403_0201);
    check("bo_lane1", lane(o_state, 1), 64'h0000_0000_0000_001F);
    check("bo_lane20", lane(o_state, 20), 64'h8000_0000_0000_0000);

    // Block boundary: 21 full words, last one closes the block
    do_reset;
    do_start;
    pcnt = 0;
    for (int k = 0; k < 21; k++) send(64'(k + 1) << 56, (k == 20), 4'd8);
    wait_pstart(1'b0, ok);
    check("blk1_lane0", lane(o_state, 0), 64'd1);
    check("blk1_lane20", lane(o_state, 20), 64'd21);
    check("blk1_lane21", lane(o_state, 21), 64'd0);
    p1 = pat(1);
    finish_perm(p1);
    wait_pstart(1'b0, ok);
    check("blk2_lane0", lane(o_state, 0), lane(p1, 0) ^ 64'h1F);
    check("blk2_lane20", lane(o_state, 20), lane(p1, 20) ^ 64'h8000_0000_0000_0000);
    check("blk2_lane7", lane(o_state, 7), lane(p1, 7));
    check("blk2_lane24", lane(o_state, 24), lane(p1, 24));
    check("blk2_notdone", {63'b0, o_done}, 64'd0);
    p2 = pat(2);
    finish_perm(p2);
    check("blk_done", {63'b0, o_done}, 64'd1);
    check("blk_final", lane(o_state, 3), lane(p2, 3));
    check("blk_pulses", 64'(pcnt), 64'd2);
    // Words offered in DONE change nothing
    held = lane(o_state, 0);
    i_valid = 1'b1; i_data = 64'hFFFF_FFFF_FFFF_FFFF; i_last = 1'b1; i_bytes = 4'd8;
    @(negedge i_clk);
    i_valid = 1'b0; i_last = 1'b0;
    check("done_frozen", lane(o_state, 0), held);
    check("done_held", {63'b0, o_done}, 64'd1);

    // Shared pad byte with a single-lane rate
    do_reset;
    do_start;
    send(64'h11223344_55667788, 1'b1, 4'd7);
    wait_pstart(1'b1, ok);
    check("shared_lane0", lane(o_state1, 0), 64'h9F77_6655_4433_2211);
    check("shared_lane1", lane(o_state1, 1), 64'h0);

    // Reset during PERM, then a late i_perm_done
    do_reset;
    do_start;
    send(64'h0, 1'b1, 4'd0);
    wait_pstart(1'b0, ok);
    i_rstn = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1; i_perm_done = 1'b1; i_perm_state = pat(3);
    @(negedge i_clk);
    i_perm_done = 1'b0;
    check("abort_ready", {63'b0, o_ready}, 64'd0);
    check("abort_pstart", {63'b0, o_perm_start}, 64'd0);
    check("abort_done", {63'b0, o_done}, 64'd0);
    check("abort_state", {63'b0, |o_state}, 64'd0);
    do_start;
    check("restart_ready", {63'b0, o_ready}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
